// File: rtl/fm_wm_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// fm_wm_pingpong_buffer: two-bank FMxWM result store, producer fills/accumulates
// one bank while the consumer reads rows from the other.     Revision: 1.0
// ============================================================================
module fm_wm_pingpong_buffer #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
  parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_en,
  input  logic                                         wr_acc,
  input  logic [FEATURE_WIDTH-1:0]                     wr_row,
  input  logic [WEIGHT_WIDTH-1:0]                      wr_col,
  input  logic [DOT_PROD_WIDTH-1:0]                    wr_data,
  input  logic                                         wr_commit,
  output logic                                         wr_ready,
  input  logic                                         rd_en,
  input  logic [FEATURE_WIDTH-1:0]                     rd_row,
  input  logic                                         rd_release,
  output logic                                         rd_avail,
  output logic                                         rd_valid,
  output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]   rd_data
);

  typedef enum logic [1:0] {
    BANK_FREE = 2'd0,
    BANK_FILL = 2'd1,
    BANK_FULL = 2'd2
  } bank_state_t;

  typedef logic signed [DOT_PROD_WIDTH-1:0] elem_t;

  localparam logic [FEATURE_WIDTH:0] ROW_LIMIT = FEATURE_ROWS[FEATURE_WIDTH:0];
  localparam logic [WEIGHT_WIDTH:0]  COL_LIMIT = WEIGHT_COLS[WEIGHT_WIDTH:0];
  localparam elem_t ELEM_MAX = {1'b0, {(DOT_PROD_WIDTH-1){1'b1}}};
  localparam elem_t ELEM_MIN = {1'b1, {(DOT_PROD_WIDTH-1){1'b0}}};

  bank_state_t state_q [2];
  bank_state_t state_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  elem_t       mem_q [2][FEATURE_ROWS][WEIGHT_COLS];
  elem_t       mem_d [2][FEATURE_ROWS][WEIGHT_COLS];
  logic        rd_valid_q, rd_valid_d;
  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] rd_data_q, rd_data_d;

  logic        wr_in_range;
  logic        rd_in_range;
  logic        other_bank;

  // Sum is formed one bit wider so overflow shows up as disagreeing top bits.
  function automatic elem_t sat_add(input elem_t a, input elem_t b);
    logic signed [DOT_PROD_WIDTH:0] sum;
    sum = {a[DOT_PROD_WIDTH-1], a} + {b[DOT_PROD_WIDTH-1], b};
    if (sum[DOT_PROD_WIDTH] != sum[DOT_PROD_WIDTH-1]) begin
      return sum[DOT_PROD_WIDTH] ? ELEM_MIN : ELEM_MAX;
    end
    return sum[DOT_PROD_WIDTH-1:0];
  endfunction

  assign wr_ready    = (state_q[wr_ptr_q] == BANK_FILL);
  assign rd_avail    = (state_q[rd_ptr_q] == BANK_FULL);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign wr_in_range = ({1'b0, wr_row} < ROW_LIMIT) && ({1'b0, wr_col} < COL_LIMIT);
  assign rd_in_range = ({1'b0, rd_row} < ROW_LIMIT);
  assign other_bank  = ~wr_ptr_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    // Read sees pre-release contents because it samples mem_q, not mem_d.
    if (rd_en && rd_avail) begin
      rd_valid_d = 1'b1;
      rd_data_d  = '0;
      if (rd_in_range) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          rd_data_d[c] = mem_q[rd_ptr_q][rd_row][c];
        end
      end
    end

    if (wr_en && wr_ready && wr_in_range) begin
      if (wr_acc) begin
        mem_d[wr_ptr_q][wr_row][wr_col] = sat_add(mem_q[wr_ptr_q][wr_row][wr_col], wr_data);
      end else begin
        mem_d[wr_ptr_q][wr_row][wr_col] = wr_data;
      end
    end

    if (rd_release && rd_avail) begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          mem_d[rd_ptr_q][r][c] = '0;
        end
      end
      state_d[rd_ptr_q] = BANK_FREE;
      rd_ptr_d          = ~rd_ptr_q;
      if (!wr_ready) begin
        state_d[rd_ptr_q] = BANK_FILL;
        wr_ptr_d          = rd_ptr_q;
      end
    end

    // Evaluated after release so a bank freed this cycle is taken over at once.
    if (wr_commit && wr_ready) begin
      state_d[wr_ptr_q] = BANK_FULL;
      if (state_d[other_bank] == BANK_FREE) begin
        state_d[other_bank] = BANK_FILL;
        wr_ptr_d            = other_bank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= BANK_FILL;
      state_q[1] <= BANK_FREE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < FEATURE_ROWS; r++) begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            mem_q[b][r][c] <= '0;
          end
        end
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      mem_q      <= mem_d;
    end
  end

endmodule
`default_nettype wire
